// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and helpers for the reset sequencer.
//   state_e   - FSM state encoding, also exported on state_o
//   cnt_width - width of the single shared state counter
package rst_seq_pkg;

    typedef enum logic [2:0] {
        S_ASSERT  = 3'd0,
        S_HOLD    = 3'd1,
        S_RELEASE = 3'd2,
        S_RUN     = 3'd3,
        S_SOFT    = 3'd4
    } state_e;

    // The counter must reach the largest terminal value of any state
    // without wrapping; one extra bit keeps the +1 in HOLD/RUN safe.
    function automatic int cnt_width(input int n_ch, input int hold,
                                     input int stagger, input int div);
        int m;
        m = hold;
        if ((n_ch - 1) * stagger + 1 > m) m = (n_ch - 1) * stagger + 1;
        if (div > m) m = div;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/rst_sync.sv
// rst_sync: reset release synchroniser. Asserts asynchronously with rst,
// releases after STAGES rising edges of clk.
//   clk  in  system clock
//   rst  in  asynchronous active-low reset
//   d_i  in  value shifted in once out of reset (normally 1)
//   q_o  out synchronised release, 0 while in reset
module rst_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sync_q <= '0;
        else      sync_q <= sync_d;
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: staggered per-domain reset release with a divided
// clock-enable tick and a software re-reset handshake.
//   clk       in  system clock
//   rst       in  asynchronous active-low board reset
//   soft_req  in  level request for a soft re-reset (honoured in RUN only)
//   soft_ack  out high while the soft reset is held
//   rst_out   out per-channel active-high reset, bit 0 released first
//   tick      out one-cycle enable every DIV cycles while in RUN
//   ready     out all channels released
//   state_o   out current FSM state
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int DIV         = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            soft_req,
    output logic            soft_ack,
    output logic [N_CH-1:0] rst_out,
    output logic            tick,
    output logic            ready,
    output logic [2:0]      state_o
);

    localparam int CW = cnt_width(N_CH, HOLD_CYCLES, STAGGER, DIV);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST  = CW'((N_CH - 1) * STAGGER);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);

    logic sync_done;

    rst_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (1'b1),
        .q_o (sync_done)
    );

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_CH-1:0] rst_out_q, rst_out_d;
    logic            ready_q, ready_d;
    logic            tick_q, tick_d;
    logic            soft_ack_q, soft_ack_d;
    logic            go_run;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        rst_out_d  = rst_out_q;
        ready_d    = ready_q;
        tick_d     = 1'b0;
        soft_ack_d = soft_ack_q;
        go_run     = 1'b0;

        case (state_q)
            S_ASSERT: begin
                cnt_d      = '0;
                rst_out_d  = '1;
                ready_d    = 1'b0;
                soft_ack_d = 1'b0;
                if (sync_done) state_d = S_HOLD;
            end
            S_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (N_CH == 1) begin
                        go_run = 1'b1;
                    end else begin
                        state_d      = S_RELEASE;
                        rst_out_d[0] = 1'b0;
                    end
                end
            end
            S_RELEASE: begin
                // cnt_d is the number of cycles since RELEASE entry
                for (int i = 1; i < N_CH; i++) begin
                    if (cnt_d == CW'(i * STAGGER)) rst_out_d[i] = 1'b0;
                end
                if (cnt_d == REL_LAST) go_run = 1'b1;
            end
            S_RUN: begin
                if (soft_req) begin
                    state_d    = S_SOFT;
                    cnt_d      = '0;
                    rst_out_d  = '1;
                    ready_d    = 1'b0;
                    soft_ack_d = 1'b1;
                end else if (cnt_q == DIV_LAST) begin
                    tick_d = 1'b1;
                    cnt_d  = '0;
                end
            end
            S_SOFT: begin
                cnt_d = '0;
                if (!soft_req) begin
                    state_d    = S_HOLD;
                    soft_ack_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_ASSERT;
                cnt_d     = '0;
                rst_out_d = '1;
                ready_d   = 1'b0;
            end
        endcase

        // A request already pending at RUN entry goes straight to SOFT so
        // the channels are never released for a single cycle.
        if (go_run) begin
            cnt_d = '0;
            if (soft_req) begin
                state_d    = S_SOFT;
                rst_out_d  = '1;
                ready_d    = 1'b0;
                soft_ack_d = 1'b1;
            end else begin
                state_d   = S_RUN;
                rst_out_d = '0;
                ready_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_ASSERT;
            cnt_q      <= '0;
            rst_out_q  <= '1;
            ready_q    <= 1'b0;
            tick_q     <= 1'b0;
            soft_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_out_q  <= rst_out_d;
            ready_q    <= ready_d;
            tick_q     <= tick_d;
            soft_ack_q <= soft_ack_d;
        end
    end

    assign rst_out  = rst_out_q;
    assign ready    = ready_q;
    assign tick     = tick_q;
    assign soft_ack = soft_ack_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Bench for rst_sequencer: default instance checked every edge against a
// timeline model, plus two small instances (N_CH=1 and N_CH=8) checked
// against a power-up vector table.
module tb_rst_sequencer;

    localparam int N  = 4;
    localparam int SS = 2;
    localparam int HC = 16;
    localparam int ST = 4;
    localparam int DV = 4;
    localparam int RUN_AT = HC + (N - 1) * ST;   // edges from HOLD entry to RUN

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic soft_req = 1'b0;
    logic soft_off = 1'b0;

    logic [N-1:0] rst_out;
    logic soft_ack, tick, ready;
    logic [2:0] state_o;

    logic [0:0] rst_out1;
    logic soft_ack1, tick1, ready1;
    logic [2:0] state_o1;

    logic [7:0] rst_out2;
    logic soft_ack2, tick2, ready2;
    logic [2:0] state_o2;

    always #5 clk = ~clk;

    rst_sequencer dut (
        .clk(clk), .rst(rst), .soft_req(soft_req), .soft_ack(soft_ack),
        .rst_out(rst_out), .tick(tick), .ready(ready), .state_o(state_o)
    );

    rst_sequencer #(.N_CH(1), .HOLD_CYCLES(1), .DIV(2)) dut1 (
        .clk(clk), .rst(rst), .soft_req(soft_off), .soft_ack(soft_ack1),
        .rst_out(rst_out1), .tick(tick1), .ready(ready1), .state_o(state_o1)
    );

    rst_sequencer #(.N_CH(8), .STAGGER(1)) dut2 (
        .clk(clk), .rst(rst), .soft_req(soft_off), .soft_ack(soft_ack2),
        .rst_out(rst_out2), .tick(tick2), .ready(ready2), .state_o(state_o2)
    );

    int n_vec = 0;
    int n_err = 0;
    int ec    = 0;   // edges since rst release

    // Timeline model: 0 = waiting for sync, 1 = sequence (t edges since HOLD
    // entry), 2 = soft reset held.
    int m_mode = 0;
    int m_e    = 0;
    int m_t    = 0;

    function automatic logic [31:0] e0(input int s, input logic rd, input logic tk,
                                       input logic sa, input logic [3:0] ro);
        return 32'({s[2:0], rd, tk, sa, ro});
    endfunction

    function automatic logic [31:0] e1(input int s, input logic rd, input logic tk,
                                       input logic ro);
        return 32'({s[2:0], rd, tk, ro});
    endfunction

    function automatic logic [31:0] e2(input int s, input logic rd, input logic [7:0] ro);
        return 32'({s[2:0], rd, ro});
    endfunction

    function automatic logic [31:0] got(input int d);
        case (d)
            1:       return e1(32'(state_o1), ready1, tick1, rst_out1[0]);
            2:       return e2(32'(state_o2), ready2, rst_out2);
            default: return e0(32'(state_o), ready, tick, soft_ack, rst_out);
        endcase
    endfunction

    function automatic logic [31:0] m_out();
        logic [3:0] ro;
        int s;
        logic rd, tk, sa;
        ro = '1; s = 0; rd = 1'b0; tk = 1'b0; sa = 1'b0;
        if (m_mode == 1) begin
            if (m_t < HC) begin
                s = 1;
            end else begin
                for (int i = 0; i < N; i++) ro[i] = (m_t - HC < i * ST);
                if (m_t >= RUN_AT) begin
                    s  = 3;
                    rd = 1'b1;
                    tk = (m_t > RUN_AT) && ((m_t - RUN_AT) % DV == 0);
                end else begin
                    s = 2;
                end
            end
        end else if (m_mode == 2) begin
            s  = 4;
            sa = 1'b1;
        end
        return e0(s, rd, tk, sa, ro);
    endfunction

    task automatic model_step(input logic sr);
        case (m_mode)
            0: begin
                m_e++;
                if (m_e >= SS + 1) begin m_mode = 1; m_t = 0; end
            end
            1: begin
                m_t++;
                if (m_t >= RUN_AT && sr) m_mode = 2;
            end
            default: if (!sr) begin m_mode = 1; m_t = 0; end
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s edge %0d: got %h expected %h", nm, ec, act, exp);
        end
    endtask

    // One rising edge, sampled on the following falling edge.
    task automatic cycle();
        logic sr;
        sr = soft_req;
        @(posedge clk);
        model_step(sr);
        ec++;
        @(negedge clk);
        chk("model", got(0), m_out());
    endtask

    // Async reset pulse from a falling edge; outputs checked with no clock edge.
    task automatic restart();
        #2 rst = 1'b0;
        m_mode = 0; m_e = 0; m_t = 0;
        #1 chk("async_rst", got(0), e0(0, 1'b0, 1'b0, 1'b0, 4'hF));
        @(negedge clk);
        rst = 1'b1;
        ec = 0;
    endtask

    typedef struct {
        int          e;
        int          d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[$];

    initial begin
        tbl.push_back('{3,  0, e0(1, 0, 0, 0, 4'hF)});
        tbl.push_back('{18, 0, e0(1, 0, 0, 0, 4'hF)});
        tbl.push_back('{19, 0, e0(2, 0, 0, 0, 4'hE)});
        tbl.push_back('{22, 0, e0(2, 0, 0, 0, 4'hE)});
        tbl.push_back('{23, 0, e0(2, 0, 0, 0, 4'hC)});
        tbl.push_back('{27, 0, e0(2, 0, 0, 0, 4'h8)});
        tbl.push_back('{30, 0, e0(2, 0, 0, 0, 4'h8)});
        tbl.push_back('{31, 0, e0(3, 1, 0, 0, 4'h0)});
        tbl.push_back('{34, 0, e0(3, 1, 0, 0, 4'h0)});
        tbl.push_back('{35, 0, e0(3, 1, 1, 0, 4'h0)});
        tbl.push_back('{36, 0, e0(3, 1, 0, 0, 4'h0)});
        tbl.push_back('{39, 0, e0(3, 1, 1, 0, 4'h0)});
        tbl.push_back('{3,  1, e1(1, 0, 0, 1'b1)});
        tbl.push_back('{4,  1, e1(3, 1, 0, 1'b0)});
        tbl.push_back('{5,  1, e1(3, 1, 0, 1'b0)});
        tbl.push_back('{6,  1, e1(3, 1, 1, 1'b0)});
        tbl.push_back('{7,  1, e1(3, 1, 0, 1'b0)});
        tbl.push_back('{8,  1, e1(3, 1, 1, 1'b0)});
        tbl.push_back('{18, 2, e2(1, 0, 8'hFF)});
        tbl.push_back('{19, 2, e2(2, 0, 8'hFE)});
        tbl.push_back('{20, 2, e2(2, 0, 8'hFC)});
        tbl.push_back('{25, 2, e2(2, 0, 8'h80)});
        tbl.push_back('{26, 2, e2(3, 1, 8'h00)});

        // Reset state of every instance
        repeat (3) @(negedge clk);
        chk("reset0", got(0), e0(0, 0, 0, 0, 4'hF));
        chk("reset1", got(1), e1(0, 0, 0, 1'b1));
        chk("reset2", got(2), e2(0, 0, 8'hFF));
        rst = 1'b1;
        ec  = 0;

        // Power-up sequence: model every edge plus the vector table
        for (int e = 1; e <= 40; e++) begin
            cycle();
            foreach (tbl[k])
                if (tbl[k].e == ec) chk("table", got(tbl[k].d), tbl[k].exp);
        end

        // rst dropped mid-RELEASE, then a full repeat of the sequence
        restart();
        repeat (24) cycle();
        chk("mid_release", got(0), e0(2, 0, 0, 0, 4'hC));
        restart();
        repeat (31) cycle();
        chk("rerun_ready", got(0), e0(3, 1, 0, 0, 4'h0));

        // Soft reset in RUN for 5 cycles
        repeat (3) cycle();
        soft_req = 1'b1;
        repeat (5) begin
            cycle();
            chk("soft_hold", got(0), e0(4, 0, 0, 1, 4'hF));
        end
        soft_req = 1'b0;
        cycle();
        chk("soft_exit", got(0), e0(1, 0, 0, 0, 4'hF));
        repeat (15) cycle();
        chk("soft_hold_end", got(0), e0(1, 0, 0, 0, 4'hF));
        cycle();
        chk("soft_rel0", got(0), e0(2, 0, 0, 0, 4'hE));

        // soft_req held from edge 5 through edge 40
        restart();
        repeat (4) cycle();
        soft_req = 1'b1;
        for (int e = 5; e <= 40; e++) begin
            cycle();
            if (ec == 30) chk("soft_ignored", got(0), e0(2, 0, 0, 0, 4'h8));
            if (ec == 31) chk("soft_at_run", got(0), e0(4, 0, 0, 1, 4'hF));
        end
        soft_req = 1'b0;
        cycle();
        chk("soft_drop", got(0), e0(1, 0, 0, 0, 4'hF));

        // Randomised soft requests and occasional resets against the model
        restart();
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 11) == 0) soft_req = ~soft_req;
            if ($urandom_range(0, 299) == 0) restart();
            else cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Parametrised reset/clock-enable sequencer between board-level reset and the CPU pipeline and its peripherals. It takes the raw asynchronous active-low reset and drives N_CH per-domain, active-high, synchronous-release resets in a fixed staggered order. It also provides a divided clock-enable tick and a software-requested re-reset handshake. It replaces ad-hoc single-shot reset release in the top level.

## Interface
- N_CH, 4: number of reset channels, 1..32
- SYNC_STAGES, 2: reset-deassert synchroniser depth, ≥2
- HOLD_CYCLES, 16: cycles all channels stay asserted after synchronised release, ≥1
- STAGGER, 4: cycles between consecutive channel releases, ≥1
- DIV, 4: tick period in cycles, ≥2

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- soft_req  in  1  level request for a soft re-reset
- soft_ack  out  1  high while a soft reset is held
- rst_out  out  N_CH  per-channel reset, active-high; bit 0 releases first
- tick  out  1  one-cycle clock-enable pulse every DIV cycles, RUN only
- ready  out  1  all channels released
- state_o  out  3  current state: ASSERT=0, HOLD=1, RELEASE=2, RUN=3, SOFT=4

## Operation
- rst low drives these values immediately, independent of clk:
  - state=ASSERT
  - rst_out all ones
  - ready=0, tick=0, soft_ack=0
  - synchroniser cleared
  - counters zero
- ASSERT: wait for the synchroniser output to go 1, then go to HOLD with counter=0.
- HOLD: count HOLD_CYCLES cycles with all channels asserted, then go to RELEASE.
- RELEASE:
  - rst_out[0] clears on the RELEASE entry edge.
  - rst_out[i] clears i·STAGGER cycles after entry.
  - The edge that clears rst_out[N_CH-1] also enters RUN and sets ready=1.
  - With N_CH=1, HOLD goes directly to RUN and the single channel clears on that edge.
- RUN:
  - tick pulses for one cycle every DIV cycles.
  - The first tick comes DIV cycles after RUN entry.
  - The divider counter restarts at every RUN entry.
- Soft reset:
  - soft_req is sampled only in RUN; a high sample enters SOFT.
  - In SOFT: rst_out all ones, ready=0, tick=0, soft_ack=1.
  - SOFT holds while soft_req=1.
  - The first edge sampling soft_req=0 clears soft_ack and enters HOLD with counter=0.
  - soft_req high outside RUN is ignored and not latched.
  - A request still held when RUN is next reached starts a new SOFT.
- rst low in any state, including mid-RELEASE or SOFT, returns to ASSERT asynchronously.
  - Partially released channels reassert at once.
- Width rules:
  - One shared counter of width $clog2(max(HOLD_CYCLES, (N_CH-1)·STAGGER+1, DIV))+1.
  - The counter never wraps within a state and is reset at each state entry.

## Timing
- Edge numbering: edge 1 is the first rising edge with rst high. Defaults apply unless stated.
- Synchroniser: output goes 1 at edge SYNC_STAGES (2).
- HOLD is entered at edge SYNC_STAGES+1 (3).
- RELEASE entry and rst_out[0]=0 at edge SYNC_STAGES+1+HOLD_CYCLES (19).
- Channel releases: rst_out[1] at edge 23, rst_out[2] at edge 27, rst_out[3] at edge 31.
- ready=1 at edge 31; tick high after edges 35, 39, 43, …
- Soft-reset latency:
  - soft_req sampled high at edge k gives registered SOFT outputs at edge k.
  - soft_req sampled low at edge m gives HOLD at edge m.
  - That is followed by rst_out[0] release at m+HOLD_CYCLES.
- All outputs are registered; no combinational path from soft_req to any output.
- rst deassertion is never used combinationally; only the synchroniser output is used.

## Structure
- Package rst_seq_pkg holds the state typedef, the encodings ASSERT..SOFT, and the counter-width function.
- One sub-module, rst_sync: SYNC_STAGES-deep asynchronous-assert, synchronous-deassert chain with 1-bit in/out, reset by rst.
- The FSM, counter, channel mask register and tick generator live in rst_sequencer.

## Test plan
- Power-up with defaults, rst released between edges:
  - state_o=1 at edge 3.
  - rst_out=4'b1110 at edge 19, 4'b1100 at 23, 4'b1000 at 27, 4'b0000 with ready=1 at 31.
  - tick at 35 and 39.
- rst pulsed low mid-RELEASE at edge 24: rst_out=4'b1111, ready=0, state_o=0 with no clock edge. On re-release the full sequence repeats from edge 1.
- Soft reset in RUN, soft_req high for 5 cycles:
  - soft_ack=1, rst_out=4'b1111, tick=0 throughout.
  - After soft_req drops: HOLD, then rst_out[0] clears 16 cycles later.
- soft_req held high from edge 5 through edge 40:
  - Ignored during HOLD/RELEASE.
  - SOFT entered at edge 31, the RUN entry edge, and held until soft_req drops.
- N_CH=1, HOLD_CYCLES=1, DIV=2: rst_out=0 and ready=1 at edge 4; tick every 2 cycles from edge 6.
- N_CH=8, STAGGER=1: channels clear on consecutive edges 19..26, ready at 26.
